key_debounce: RTL and testbench

Conditions the two raw push-buttons (write key, read key) before they reach the I2C EEPROM controller. Each input is synchronised and debounced, and it produces a clean level plus a one-cycle press strobe. The strobes drive the controller's write/read triggers; the debounced levels remain available for status display. The block sits directly upstream of the I2C top level, between the board pins and `sw1`/`sw2`.

---
 rtl/key_debounce_if.sv | 28 ++
 rtl/key_debounce.sv | 166 ++++++++++++++++
 tb/tb_key_debounce.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/key_debounce_if.sv
// key_debounce_if: pin-side keys and conditioned key outputs.
// master drives raw keys, slave (the debouncer) drives strobes/levels.
interface key_debounce_if;
  logic key1_n;
  logic key2_n;
  logic sw1;
  logic sw2;
  logic key1_lvl;
  logic key2_lvl;

  modport master (
    output key1_n,
    output key2_n,
    input  sw1,
    input  sw2,
    input  key1_lvl,
    input  key2_lvl
  );

  modport slave (
    input  key1_n,
    input  key2_n,
    output sw1,
    output sw2,
    output key1_lvl,
    output key2_lvl
  );
endinterface

// File: rtl/key_debounce.sv
// key_debounce: sync + debounce two active-low keys into levels and
// one-cycle press strobes for the I2C EEPROM write/read triggers.
// Ports: clk, rst (sync, active high), bus (key_debounce_if.slave):
//   key1_n/key2_n raw keys in; sw1/sw2 strobes, key1_lvl/key2_lvl out.
// Optional macro KEY_REPEAT_EN adds auto-repeat strobes while held.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned REPEAT_DELAY    = 25_000_000,
  parameter int unsigned REPEAT_PERIOD   = 10_000_000
) (
  input logic          clk,
  input logic          rst,
  key_debounce_if.slave bus
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LP_CMAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_REL,
    S_PW,
    S_PR,
    S_RW
  } state_t;

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 32'h00FF_FFFF) begin : g_bad_deb
    $error("DEBOUNCE_CYCLES out of range");
  end
  if (REPEAT_DELAY < 2 || REPEAT_PERIOD < 1 ||
      REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_rep
    $error("REPEAT_DELAY/REPEAT_PERIOD out of range");
  end

  // bit 0 = key1 (write), bit 1 = key2 (read)
  logic [1:0] r_s1;
  logic [1:0] r_s2;
  logic [1:0] w_in;
  logic [1:0] w_arm;
  logic [1:0] w_lvl;
  logic [1:0] r_lvl;
  logic [1:0] r_sw;

  // Synchroniser resets to the released level so a held key
  // is seen as a fresh press once reset drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= 2'b11;
      r_s2 <= 2'b11;
    end else begin
      r_s1 <= {bus.key2_n, bus.key1_n};
      r_s2 <= r_s1;
    end
  end

  assign w_in = ~r_s2;

  for (genvar g = 0; g < 2; g++) begin : g_key
    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic          w_arm_g;
    logic          w_lvl_g;
    logic          w_rep_g;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_state <= S_REL;
      end else begin
        r_state <= w_next;
      end
    end

    // Saturating stability counter, cleared on every state entry.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_cnt <= '0;
      end else if (w_next != r_state) begin
        r_cnt <= '0;
      end else if ((r_state == S_PW || r_state == S_RW) &&
                   r_cnt != LP_CMAX) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    always_comb begin
      w_next = r_state;
      unique case (r_state)
        S_REL: begin
          if (w_in[g]) w_next = S_PW;
        end
        S_PW: begin
          if (!w_in[g]) w_next = S_REL;
          else if (r_cnt == LP_CMAX) w_next = S_PR;
        end
        S_PR: begin
          if (!w_in[g]) w_next = S_RW;
        end
        S_RW: begin
          if (w_in[g]) w_next = S_PR;
          else if (r_cnt == LP_CMAX) w_next = S_REL;
        end
        default: w_next = S_REL;
      endcase
    end

`ifdef KEY_REPEAT_EN
    localparam int RW = $clog2(REPEAT_DELAY);
    localparam logic [RW-1:0] LP_RMAX  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] LP_RLOAD =
      RW'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [RW-1:0] r_rcnt;

    // After the first repeat the counter restarts part way up so
    // later repeats come every REPEAT_PERIOD cycles.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_rcnt <= '0;
      end else if (r_state != S_PR || w_next != S_PR) begin
        r_rcnt <= '0;
      end else if (r_rcnt == LP_RMAX) begin
        r_rcnt <= LP_RLOAD;
      end else begin
        r_rcnt <= r_rcnt + 1'b1;
      end
    end

    assign w_rep_g = (r_state == S_PR) && (w_next == S_PR) &&
                     (r_rcnt == LP_RMAX);
`else
    assign w_rep_g = 1'b0;
`endif

    // Outputs are decoded from the next state and registered below,
    // so strobe and level move on the same edge as the state.
    always_comb begin
      w_arm_g = 1'b0;
      w_lvl_g = 1'b0;
      if (r_state == S_PW && w_next == S_PR) w_arm_g = 1'b1;
      if (w_rep_g) w_arm_g = 1'b1;
      if (w_next == S_PR || w_next == S_RW) w_lvl_g = 1'b1;
    end

    assign w_arm[g] = w_arm_g;
    assign w_lvl[g] = w_lvl_g;
  end

  // Write wins a same-cycle tie; a strobe is dropped while the
  // other key is down so the controller never sees both requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lvl <= 2'b00;
      r_sw  <= 2'b00;
    end else begin
      r_lvl   <= w_lvl;
      r_sw[0] <= w_arm[0] && !r_lvl[1];
      r_sw[1] <= w_arm[1] && !w_arm[0] && !r_lvl[0];
    end
  end

  assign bus.sw1      = r_sw[0];
  assign bus.sw2      = r_sw[1];
  assign bus.key1_lvl = r_lvl[0];
  assign bus.key2_lvl = r_lvl[1];

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed press/bounce/tie/reset/hold stimulus;
// expected strobes queued by stimulus, popped by a strobe monitor.
module tb_key_debounce;

  localparam int DEB = 16;
  localparam int RD  = 64;
  localparam int RP  = 32;
  // 2 sync edges + entry edge + DEB-1 counts + transition edge
  localparam int LAT = DEB + 3;

  typedef struct {
    int key;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  exp_t exp_q[$];

  key_debounce_if dut_if ();

  key_debounce #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(dut_if.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", nm, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expected strobes for a press driven at cycle t and held hold cycles.
  // A repeat can still fire on the edge two cycles after release.
  task automatic push_press(input int k, input int t, input int hold);
    exp_t e;
    e.key = k;
    e.cyc = t + LAT;
    exp_q.push_back(e);
`ifdef KEY_REPEAT_EN
    for (int tt = t + LAT + RD; tt <= t + hold + 2; tt += RP) begin
      e.cyc = tt;
      exp_q.push_back(e);
    end
`endif
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    int   k;
    if (dut_if.sw1 || dut_if.sw2) begin
      k = dut_if.sw1 ? 1 : 2;
      if (dut_if.sw1 && dut_if.sw2) begin
        n_chk++;
        $display("FAIL strobe_both: sw1 and sw2 high at cyc %0d", cyc);
      end
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL strobe_unexp: key %0d at cyc %0d, want none",
                 k, cyc);
      end else begin
        e = exp_q.pop_front();
        n_chk++;
        if (e.key == k && e.cyc == cyc) n_pass++;
        else $display("FAIL strobe: key %0d cyc %0d, want key %0d cyc %0d",
                      k, cyc, e.key, e.cyc);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit reached, want finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int t;
    int hi;
    dut_if.key1_n = 1'b1;
    dut_if.key2_n = 1'b1;
    rst = 1'b1;
    tick(3);
    chk("reset_outs", {dut_if.sw1, dut_if.sw2,
                       dut_if.key1_lvl, dut_if.key2_lvl}, 0);
    rst = 1'b0;
    tick(5);

    // clean press on key1, 100 cycles
    t = cyc;
    dut_if.key1_n = 1'b0;
    push_press(1, t, 100);
    tick(LAT - 1);
    chk("clean_lvl1_pre", dut_if.key1_lvl, 0);
    tick(1);
    chk("clean_lvl1_rise", dut_if.key1_lvl, 1);
    chk("clean_lvl2", dut_if.key2_lvl, 0);
    tick(100 - LAT);
    dut_if.key1_n = 1'b1;
    tick(LAT - 1);
    chk("clean_lvl1_hold", dut_if.key1_lvl, 1);
    tick(1);
    chk("clean_lvl1_fall", dut_if.key1_lvl, 0);
    tick(10);

    // key2 bounce: 5-cycle toggles for 60 cycles, then held
    hi = 0;
    for (int i = 0; i < 12; i++) begin
      dut_if.key2_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat (5) begin
        @(negedge clk);
        if (dut_if.key2_lvl) hi = 1;
      end
    end
    chk("bounce_lvl2", hi, 0);
    t = cyc;
    dut_if.key2_n = 1'b0;
    push_press(2, t, 33);
    tick(LAT);
    chk("bounce_lvl2_rise", dut_if.key2_lvl, 1);
    tick(10);
    dut_if.key2_n = 1'b1;
    tick(3);
    dut_if.key2_n = 1'b0;
    hi = 1;
    repeat (20) begin
      @(negedge clk);
      if (!dut_if.key2_lvl) hi = 0;
    end
    chk("glitch_lvl2_kept", hi, 1);
    dut_if.key2_n = 1'b1;
    tick(25);
    chk("bounce_lvl2_fall", dut_if.key2_lvl, 0);

    // simultaneous press: write wins, read dropped for good
    t = cyc;
    dut_if.key1_n = 1'b0;
    dut_if.key2_n = 1'b0;
    push_press(1, t, 50);
    tick(20);
    chk("tie_lvl1", dut_if.key1_lvl, 1);
    chk("tie_lvl2", dut_if.key2_lvl, 1);
    tick(30);
    dut_if.key1_n = 1'b1;
    tick(22);
    chk("tie_lvl1_fall", dut_if.key1_lvl, 0);
    chk("tie_lvl2_held", dut_if.key2_lvl, 1);
    tick(3);
    dut_if.key2_n = 1'b1;
    tick(25);
    chk("tie_lvl2_fall", dut_if.key2_lvl, 0);

    // reset 10 cycles into PRESS_WAIT, key kept held
    dut_if.key1_n = 1'b0;
    tick(13);
    rst = 1'b1;
    hi = 0;
    repeat (3) begin
      @(negedge clk);
      if (dut_if.sw1 || dut_if.sw2 ||
          dut_if.key1_lvl || dut_if.key2_lvl) hi = 1;
    end
    chk("midrst_outs", hi, 0);
    t = cyc;
    rst = 1'b0;
    push_press(1, t, 40);
    tick(LAT);
    chk("midrst_lvl1", dut_if.key1_lvl, 1);
    tick(40 - LAT);
    dut_if.key1_n = 1'b1;
    tick(25);

    // long 200-cycle hold
    t = cyc;
    dut_if.key1_n = 1'b0;
    push_press(1, t, 200);
    tick(200);
    dut_if.key1_n = 1'b1;
    tick(40);
    chk("hold_lvl1_fall", dut_if.key1_lvl, 0);

    tick(10);
    chk("strobes_missing", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
